// File: rtl/dn_cfg_pkg.sv
// Shared types and constants for the download configuration stage:
// FSM states, ioctl stream indices and game-variant (mod) codes.
package dn_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD_ROM = 2'd1,
    ST_LOAD_CFG = 2'd2,
    ST_HOLD     = 2'd3
  } state_t;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_MOD = 8'd1;
  localparam logic [7:0] IDX_DIP = 8'd254;

  localparam logic [7:0] MOD_BWIDOW   = 8'd0;
  localparam logic [7:0] MOD_GRAVITAR = 8'd1;
  localparam logic [7:0] MOD_LUNARBAT = 8'd2;
  localparam logic [7:0] MOD_SPACDUEL = 8'd3;

  // Unknown codes decode to no variant selected at all.
  function automatic logic [3:0] mod_onehot_of(input logic [7:0] code);
    logic [3:0] oh;
    oh = 4'b0000;
    case (code)
      MOD_BWIDOW:   oh = 4'b0001;
      MOD_GRAVITAR: oh = 4'b0010;
      MOD_LUNARBAT: oh = 4'b0100;
      MOD_SPACDUEL: oh = 4'b1000;
      default:      oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/dn_cfg_loader.sv
// Demultiplexes the ioctl download stream into ROM writes, the mod register
// and DIP bytes, and holds the core in reset around every download.
module dn_cfg_loader
  import dn_cfg_pkg::*;
#(
  parameter int ROM_AW      = 16,
  parameter int RESET_HOLD  = 1024,
  parameter int MOD_DEFAULT = 0
) (
  input  logic              clk_12,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_index,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              rom_wr,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [7:0]        rom_data,
  output logic [3:0]        mod_onehot,
  output logic [63:0]       dip_bus,
  output logic              core_reset,
  output logic [ROM_AW:0]   rom_bytes,
  output logic              cfg_err
);

  localparam int          HW        = $clog2(RESET_HOLD) + 1;
  localparam logic [25:0] ROM_LIMIT = 26'd1 << ROM_AW;
  localparam logic [ROM_AW:0] BYTES_MAX = {1'b1, {ROM_AW{1'b0}}};
  localparam logic [7:0]  MOD_RESET = 8'(MOD_DEFAULT);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(RESET_HOLD - 1);

  state_t            state_q, state_d;
  logic [7:0]        idx_q, idx_d;
  logic [HW-1:0]     cnt_q, cnt_d;
  logic              rom_wr_q, rom_wr_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic [7:0]        rom_data_q, rom_data_d;
  logic [ROM_AW:0]   rom_bytes_q, rom_bytes_d;
  logic [7:0]        mod_q, mod_d;
  logic [7:0]        dip_q [8];
  logic [7:0]        dip_d [8];
  logic              core_reset_q, core_reset_d;
  logic              cfg_err_q, cfg_err_d;

  logic start_rom, start_cfg, addr_in_rom;

  assign start_rom   = ioctl_download && (ioctl_index == IDX_ROM);
  assign start_cfg   = ioctl_download &&
                       ((ioctl_index == IDX_MOD) || (ioctl_index == IDX_DIP));
  assign addr_in_rom = ({1'b0, ioctl_addr} < ROM_LIMIT);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    rom_wr_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    rom_data_d  = rom_data_q;
    rom_bytes_d = rom_bytes_q;
    mod_d       = mod_q;
    dip_d       = dip_q;
    cfg_err_d   = cfg_err_q;

    case (state_q)
      ST_IDLE, ST_HOLD: begin
        // Writes are ignored here; a new download also abandons any hold count.
        if (start_rom) begin
          state_d     = ST_LOAD_ROM;
          idx_d       = ioctl_index;
          rom_bytes_d = '0;
        end else if (start_cfg) begin
          state_d = ST_LOAD_CFG;
          idx_d   = ioctl_index;
        end else if (state_q == ST_HOLD) begin
          if (cnt_q == '0) state_d = ST_IDLE;
          else             cnt_d   = cnt_q - HW'(1);
        end
      end
      ST_LOAD_ROM: begin
        if (ioctl_wr) begin
          if (addr_in_rom) begin
            rom_wr_d   = 1'b1;
            rom_addr_d = ioctl_addr[ROM_AW-1:0];
            rom_data_d = ioctl_dout;
            if (rom_bytes_q != BYTES_MAX) rom_bytes_d = rom_bytes_q + 1'b1;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
        if (!ioctl_download) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      ST_LOAD_CFG: begin
        if (ioctl_wr) begin
          if (idx_q == IDX_MOD) begin
            if (ioctl_addr == 25'd0) begin
              mod_d = ioctl_dout;
              if (ioctl_dout > MOD_SPACDUEL) cfg_err_d = 1'b1;
            end
          end else if (ioctl_addr < 25'd8) begin
            dip_d[ioctl_addr[2:0]] = ioctl_dout;
          end
        end
        if (!ioctl_download) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    core_reset_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_12) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= IDX_ROM;
      cnt_q        <= '0;
      rom_wr_q     <= 1'b0;
      rom_addr_q   <= '0;
      rom_data_q   <= '0;
      rom_bytes_q  <= '0;
      mod_q        <= MOD_RESET;
      dip_q        <= '{default: '0};
      core_reset_q <= 1'b1;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      rom_wr_q     <= rom_wr_d;
      rom_addr_q   <= rom_addr_d;
      rom_data_q   <= rom_data_d;
      rom_bytes_q  <= rom_bytes_d;
      mod_q        <= mod_d;
      dip_q        <= dip_d;
      core_reset_q <= core_reset_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign rom_wr     = rom_wr_q;
  assign rom_addr   = rom_addr_q;
  assign rom_data   = rom_data_q;
  assign rom_bytes  = rom_bytes_q;
  assign mod_onehot = mod_onehot_of(mod_q);
  assign core_reset = core_reset_q;
  assign cfg_err    = cfg_err_q;

  for (genvar gi = 0; gi < 8; gi++) begin : g_dip
    assign dip_bus[8*gi +: 8] = dip_q[gi];
  end

endmodule

// File: tb/tb_dn_cfg_loader.sv
// Randomized scoreboard bench for dn_cfg_loader: ROM writes are queued at
// issue time and popped by an independent monitor; config state is modelled.
module tb_dn_cfg_loader;

  localparam int ROM_AW = 16;
  localparam int RH     = 1024;

  logic        clk_12 = 1'b0;
  logic        reset;
  logic        ioctl_download, ioctl_wr;
  logic [7:0]  ioctl_index, ioctl_dout;
  logic [24:0] ioctl_addr;
  logic        rom_wr, core_reset, cfg_err;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic [3:0]  mod_onehot;
  logic [63:0] dip_bus;
  logic [16:0] rom_bytes;

  dn_cfg_loader #(.ROM_AW(ROM_AW), .RESET_HOLD(RH), .MOD_DEFAULT(0)) dut (
    .clk_12(clk_12), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .rom_wr(rom_wr), .rom_addr(rom_addr), .rom_data(rom_data),
    .mod_onehot(mod_onehot), .dip_bus(dip_bus), .core_reset(core_reset),
    .rom_bytes(rom_bytes), .cfg_err(cfg_err)
  );

  always #5 clk_12 = ~clk_12;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          in_load = 1'b0;
  logic [7:0]  cur_idx = 8'd0;
  int          rom_bytes_m = 0;
  bit          err_m = 1'b0;
  int          mod_m = 0;
  logic [7:0]  dip_m [8];
  logic [23:0] exp_q [$];
  bit          scramble = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
    else $display("ok   %s = %0h", name, act);
  endtask

  task automatic model_reset();
    in_load = 1'b0;
    rom_bytes_m = 0;
    err_m = 1'b0;
    mod_m = 0;
    for (int k = 0; k < 8; k++) dip_m[k] = 8'h00;
  endtask

  task automatic model_write(input logic [24:0] a, input logic [7:0] d);
    if (!in_load) return;
    if (cur_idx == 8'd0) begin
      if (a < 25'(1 << ROM_AW)) begin
        exp_q.push_back({a[15:0], d});
        if (rom_bytes_m < (1 << ROM_AW)) rom_bytes_m++;
      end else err_m = 1'b1;
    end else if (cur_idx == 8'd1) begin
      if (a == 0) begin
        mod_m = int'(d);
        if (d > 8'd3) err_m = 1'b1;
      end
    end else if (a < 8) begin
      dip_m[a[2:0]] = d;
    end
  endtask

  task automatic chk_cfg(input string tag);
    logic [63:0] dexp;
    logic [3:0]  mexp;
    for (int k = 0; k < 8; k++) dexp[8*k +: 8] = dip_m[k];
    mexp = (mod_m <= 3) ? 4'(1 << mod_m) : 4'b0000;
    chk({tag, "_mod"}, 64'(mod_onehot), 64'(mexp));
    chk({tag, "_dip"}, dip_bus, dexp);
    chk({tag, "_err"}, 64'(cfg_err), 64'(err_m));
    chk({tag, "_rom_bytes"}, 64'(rom_bytes), 64'(rom_bytes_m));
  endtask

  // All tasks start and end just after a falling edge.
  task automatic start_dl(input logic [7:0] idx);
    ioctl_download = 1'b1;
    ioctl_index = idx;
    ioctl_wr = 1'b0;
    @(negedge clk_12);
    if (idx == 8'd0 || idx == 8'd1 || idx == 8'd254) begin
      in_load = 1'b1;
      cur_idx = idx;
      if (idx == 8'd0) rom_bytes_m = 0;
    end
    chk("core_reset_start", 64'(core_reset), 64'(in_load));
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    if (scramble) ioctl_index = 8'($urandom);
    model_write(a, d);
    @(negedge clk_12);
    ioctl_wr = 1'b0;
    chk("core_reset_load", 64'(core_reset), 64'(in_load));
    repeat ($urandom_range(0, 2)) @(negedge clk_12);
  endtask

  task automatic end_dl(input bit with_wr, input logic [24:0] a, input logic [7:0] d);
    int n;
    ioctl_download = 1'b0;
    if (with_wr) begin
      ioctl_wr = 1'b1;
      ioctl_addr = a;
      ioctl_dout = d;
      model_write(a, d);
    end
    @(negedge clk_12);
    ioctl_wr = 1'b0;
    in_load = 1'b0;
    n = 0;
    while (core_reset === 1'b1 && n < RH + 20) begin
      n++;
      @(negedge clk_12);
    end
    chk("hold_cycles", 64'(n), 64'(RH));
  endtask

  // Monitor: every ROM strobe must match the oldest expected write.
  initial begin
    logic [23:0] e;
    forever begin
      @(negedge clk_12);
      if (rom_wr === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rom_wr_unexpected: got addr %0h data %0h expected no write", rom_addr, rom_data);
        end else begin
          e = exp_q.pop_front();
          if ({rom_addr, rom_data} !== e) begin
            n_fail++;
            $display("FAIL rom_wr_match: got %0h/%0h expected %0h/%0h", rom_addr, rom_data, e[23:8], e[7:0]);
          end else $display("ok   rom_wr %0h <= %0h", rom_addr, rom_data);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_index = 8'd0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    model_reset();
    repeat (3) @(negedge clk_12);

    chk("rst_rom_wr", 64'(rom_wr), 64'd0);
    chk("rst_rom_addr", 64'(rom_addr), 64'd0);
    chk("rst_rom_data", 64'(rom_data), 64'd0);
    chk("rst_core_reset", 64'(core_reset), 64'd1);
    chk_cfg("rst");
    reset = 1'b0;
    @(negedge clk_12);
    chk("core_reset_release", 64'(core_reset), 64'd0);

    // Fixed ROM download
    start_dl(8'd0);
    wr_byte(25'd0, 8'hA5);
    wr_byte(25'd1, 8'h5A);
    wr_byte(25'd2, 8'h00);
    wr_byte(25'd3, 8'hFF);
    chk_cfg("rom4");
    end_dl(1'b0, '0, '0);

    // DIP download including an ignored out-of-range byte
    start_dl(8'd254);
    for (int a = 0; a <= 8; a++) wr_byte(25'(a), 8'(8'h10 + a));
    chk("dip_literal", dip_bus, 64'h17161514_13121110);
    chk_cfg("dip");
    end_dl(1'b0, '0, '0);

    // Mod load; a non-zero address must not touch the register
    start_dl(8'd1);
    wr_byte(25'd0, 8'h02);
    chk("mod_literal", 64'(mod_onehot), 64'b0100);
    wr_byte(25'd1, 8'h05);
    chk_cfg("mod2");
    end_dl(1'b0, '0, '0);

    // Random ROM download with index wiggling, last byte on the falling cycle
    start_dl(8'd0);
    scramble = 1'b1;
    for (int i = 0; i < 12; i++) wr_byte(25'($urandom_range(0, 65535)), 8'($urandom));
    scramble = 1'b0;
    chk_cfg("rom_rand");
    ioctl_download = 1'b0;
    ioctl_wr = 1'b1;
    ioctl_addr = 25'($urandom_range(0, 65535));
    ioctl_dout = 8'($urandom);
    model_write(ioctl_addr, ioctl_dout);
    @(negedge clk_12);
    ioctl_wr = 1'b0;
    in_load = 1'b0;
    chk_cfg("rom_fall");
    for (int i = 0; i < 100; i++) begin
      chk("core_reset_hold", 64'(core_reset), 64'd1);
      @(negedge clk_12);
    end

    // Restart from HOLD, then an out-of-range ROM address
    start_dl(8'd0);
    chk("restart_rom_bytes", 64'(rom_bytes), 64'd0);
    for (int i = 0; i < 5; i++) wr_byte(25'($urandom_range(0, 65535)), 8'($urandom));
    wr_byte(25'h10000, 8'hEE);
    chk_cfg("rom_oor");
    end_dl(1'b0, '0, '0);

    // Invalid mod code
    start_dl(8'd1);
    wr_byte(25'd0, 8'h07);
    chk("mod_bad", 64'(mod_onehot), 64'd0);
    chk_cfg("mod7");
    end_dl(1'b0, '0, '0);

    // Unknown index: no reset, no writes
    start_dl(8'd5);
    wr_byte(25'd0, 8'h99);
    chk("ign_core_reset", 64'(core_reset), 64'd0);
    ioctl_download = 1'b0;
    @(negedge clk_12);

    // Reset in the middle of a DIP download, with a write in the reset cycle
    start_dl(8'd254);
    wr_byte(25'd3, 8'h3C);
    chk_cfg("dip3");
    reset = 1'b1;
    ioctl_wr = 1'b1;
    ioctl_addr = 25'd4;
    ioctl_dout = 8'h77;
    @(negedge clk_12);
    ioctl_wr = 1'b0;
    model_reset();
    chk("midrst_core_reset", 64'(core_reset), 64'd1);
    chk_cfg("midrst");
    reset = 1'b0;
    @(negedge clk_12);
    in_load = 1'b1;
    cur_idx = 8'd254;
    chk("reenter_core_reset", 64'(core_reset), 64'd1);
    wr_byte(25'd5, 8'h55);
    chk_cfg("reenter");
    end_dl(1'b0, '0, '0);

    repeat (3) @(negedge clk_12);
    chk("rom_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
